// File: rtl/coef_matrix_loader.sv
// Streams a compile-time coefficient matrix, packed PACK per word, into a coefficient RAM.
// Optional load checksum is compiled in with `define LOAD_CHECKSUM_EN.
module coef_matrix_loader #(
  parameter int                           COEF_W     = 7,
  parameter int                           PACK       = 2,
  parameter int                           ROWS       = 8,
  parameter int                           COLS       = 4,
  parameter int                           ADDR_W     = 4,
  parameter bit                           AUTO_START = 1'b1,
  parameter logic [ROWS*COLS*COEF_W-1:0]  INIT_VEC   = '0,
  parameter int                           CSUM_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     wr_ready,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        w_addr,
  output logic [COEF_W*PACK-1:0]   w_data,
  output logic                     busy,
  output logic                     load_done,
  output logic                     done_pulse,
  output logic [CSUM_W-1:0]        checksum,
  output logic [1:0]               state_dbg
);

  localparam int WORD_W = COEF_W * PACK;
  localparam int DEPTH  = ROWS * COLS / PACK;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   cnt_n;
  logic [WORD_W-1:0]   data_n;
  logic                wr_en_n, busy_n, load_done_n, done_pulse_n;
  logic                accept, enter_load;

  // Lowest coefficient index of a word lands in the most-significant slot.
  function automatic logic [WORD_W-1:0] word_at(input logic [ADDR_W-1:0] k);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int p = 0; p < PACK; p++) begin
      w[(PACK-1-p)*COEF_W +: COEF_W] = INIT_VEC[(int'(k)*PACK + p)*COEF_W +: COEF_W];
    end
    return w;
  endfunction

  // Handshake: a word is transferred on a rising edge where wr_en && wr_ready;
  // while wr_en is high and wr_ready is low, wr_en, w_addr and w_data hold.
  assign accept = wr_en && wr_ready;

  always_comb begin
    state_n      = state;
    cnt_n        = w_addr;
    data_n       = w_data;
    wr_en_n      = wr_en;
    busy_n       = busy;
    load_done_n  = load_done;
    done_pulse_n = 1'b0;
    enter_load   = 1'b0;
    unique case (state)
      IDLE: if (start || AUTO_START) enter_load = 1'b1;
      LOAD: begin
        if (accept) begin
          if (w_addr == LAST) begin
            state_n      = DONE;
            cnt_n        = '0;
            wr_en_n      = 1'b0;
            busy_n       = 1'b0;
            load_done_n  = 1'b1;
            done_pulse_n = 1'b1;
          end else begin
            cnt_n  = w_addr + ADDR_W'(1);
            data_n = word_at(cnt_n);
          end
        end
      end
      DONE: if (start) enter_load = 1'b1;
      default: state_n = IDLE;
    endcase
    if (enter_load) begin
      state_n     = LOAD;
      cnt_n       = '0;
      data_n      = word_at('0);
      wr_en_n     = 1'b1;
      busy_n      = 1'b1;
      load_done_n = 1'b0;
    end
  end

  // w_addr doubles as the load counter so the address is always registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_en      <= 1'b0;
      w_addr     <= '0;
      w_data     <= '0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      wr_en      <= wr_en_n;
      w_addr     <= cnt_n;
      w_data     <= data_n;
      busy       <= busy_n;
      load_done  <= load_done_n;
      done_pulse <= done_pulse_n;
    end
  end

  assign state_dbg = state;

`ifdef LOAD_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else if (enter_load) begin
      csum_q <= '0;
    end else if (accept) begin
      csum_q <= csum_q + CSUM_W'(w_data);
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule
